// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state constants and the signed-division boundary operands.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negate; yields |x| when i_negate is the sign bit
// and applies the final sign fix on the 64-bit datapath.
module muldiv_sign #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_negate,
  output logic [WIDTH-1:0] o_value
);

  assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared 64-bit
// accumulator, with divide-by-zero and signed overflow resolved at acceptance.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic [2:0]      mdOp,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            respValid,
  input  logic            respReady,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  import muldiv_pkg::*;

  state_t            r_state;
  logic [4:0]        r_count;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_operand;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;

  logic              w_signA, w_signB, w_negA, w_negB, w_resNeg;
  logic [XLEN-1:0]   w_magA, w_magB;
  logic              w_isDiv, w_divZero, w_ovf, w_special;
  logic [XLEN-1:0]   w_specialRes;
  logic [XLEN:0]     w_mulSum, w_remShift;
  logic [XLEN-1:0]   w_remDiff;
  logic              w_qBit;
  logic [2*XLEN-1:0] w_accNext, w_fixIn, w_fixed;
  logic [XLEN-1:0]   w_final;

  assign w_signA  = (mdOp == MD_MULH) || (mdOp == MD_MULHSU) || (mdOp == MD_DIV) || (mdOp == MD_REM);
  assign w_signB  = (mdOp == MD_MULH) || (mdOp == MD_DIV) || (mdOp == MD_REM);
  assign w_negA   = w_signA & srcA[XLEN-1];
  assign w_negB   = w_signB & srcB[XLEN-1];
  assign w_resNeg = (mdOp == MD_REM) ? w_negA : (w_negA ^ w_negB);

  muldiv_sign #(.WIDTH(XLEN)) u_absA (.i_value(srcA), .i_negate(w_negA), .o_value(w_magA));
  muldiv_sign #(.WIDTH(XLEN)) u_absB (.i_value(srcB), .i_negate(w_negB), .o_value(w_magB));

  // Both divide corner cases bypass the iteration with an architecturally fixed answer.
  assign w_isDiv      = mdOp[2];
  assign w_divZero    = w_isDiv && (srcB == '0);
  assign w_ovf        = w_isDiv && !mdOp[0] && (srcA == INT_MIN) && (srcB == ALL_ONES);
  assign w_special    = w_divZero || w_ovf;
  assign w_specialRes = w_divZero ? (mdOp[1] ? srcA : ALL_ONES)
                                  : (mdOp[1] ? '0 : INT_MIN);

  assign w_mulSum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_operand} : '0);
  assign w_remShift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_qBit     = (w_remShift >= {1'b0, r_operand});
  // When the subtraction is taken the true difference is below the divisor, so 32 bits suffice.
  assign w_remDiff  = w_remShift[XLEN-1:0] - r_operand;

  assign w_accNext = r_op[2]
    ? {(w_qBit ? w_remDiff : w_remShift[XLEN-1:0]), r_acc[XLEN-2:0], w_qBit}
    : {w_mulSum, r_acc[XLEN-1:1]};

  assign w_fixIn = r_op[2]
    ? {{XLEN{1'b0}}, (r_op[1] ? w_accNext[2*XLEN-1:XLEN] : w_accNext[XLEN-1:0])}
    : w_accNext;

  muldiv_sign #(.WIDTH(2*XLEN)) u_fix (.i_value(w_fixIn), .i_negate(r_neg), .o_value(w_fixed));

  always_comb begin
    w_final = w_fixed[XLEN-1:0];
    case (r_op)
      MD_MUL:                       w_final = w_fixed[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_fixed[2*XLEN-1:XLEN];
      default:                      w_final = w_fixed[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_op      <= MD_MUL;
      r_neg     <= 1'b0;
      r_operand <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (reqValid) begin
            r_op      <= mdOp;
            r_neg     <= w_resNeg;
            r_count   <= '0;
            r_operand <= w_isDiv ? w_magB : w_magA;
            r_acc     <= {{XLEN{1'b0}}, (w_isDiv ? w_magA : w_magB)};
            if (w_special) begin
              r_result <= w_specialRes;
              r_zero   <= (w_specialRes == '0);
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_acc   <= w_accNext;
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (respReady) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reqReady  = (r_state == ST_IDLE);
  assign respValid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, divide
// corner cases, response backpressure and reset abort mid-calculation.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  mdOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        respValid;
  logic        respReady;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady),
    .mdOp(mdOp), .srcA(srcA), .srcB(srcB),
    .respValid(respValid), .respReady(respReady),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  // Issues one request, scrambles the inputs after acceptance, waits for the
  // response (bounded), captures it and completes the handshake.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat);
    reqValid = 1'b1; mdOp = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    reqValid = 1'b0; mdOp = ~op; srcA = ~a; srcB = b ^ 32'h5A5A_5A5A;
    lat = 1;
    while (!respValid && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; z = zero;
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reqValid = 1'b0; respReady = 1'b0; mdOp = MD_MUL; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL reset reqReady: got %b want 1", reqReady); end
    checks++; if (respValid !== 1'b0) begin errors++; $display("[TB] FAIL reset respValid: got %b want 0", respValid); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL reset zero: got %b want 1", zero); end
    reset = 1'b0;
  endtask

  task automatic test_multiply();
    vec_t v[7];
    logic [31:0] res; logic z; int lat;
    v = '{'{MD_MUL,    32'd10,        32'd20,        32'd200,       33},
          '{MD_MULH,   32'd100000,    32'hFFFF_FFFE, 32'hFFFF_FFFF, 33},
          '{MD_MULHU,  32'd300000,    32'd2000,      32'h0,         33},
          '{MD_MULHSU, 32'hFFFF_FFF6, 32'd3,         32'hFFFF_FFFF, 33},
          '{MD_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33},
          '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
          '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33}};
    for (int i = 0; i < 7; i++) begin
      runOp(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("[TB] FAIL mul%0d result: got %h want %h", i, res, v[i].exp); end
      checks++; if (z !== (v[i].exp == 32'h0)) begin errors++; $display("[TB] FAIL mul%0d zero: got %b want %b", i, z, (v[i].exp == 32'h0)); end
      checks++; if (lat != v[i].lat) begin errors++; $display("[TB] FAIL mul%0d latency: got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_divide();
    vec_t v[10];
    logic [31:0] res; logic z; int lat;
    v = '{'{MD_DIVU, 32'd100,        32'd3,         32'd33,        33},
          '{MD_REMU, 32'd100,        32'd3,         32'd1,         33},
          '{MD_DIV,  32'd100,        32'hFFFF_FFFD, 32'hFFFF_FFDF, 33},
          '{MD_REM,  32'd100,        32'hFFFF_FFFD, 32'd1,         33},
          '{MD_REM,  32'hFFFF_FF9C,  32'd3,         32'hFFFF_FFFF, 33},
          '{MD_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFFD, 32'd33,        33},
          '{MD_DIVU, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33},
          '{MD_REMU, 32'hFFFF_FFFF,  32'h8000_0000, 32'h7FFF_FFFF, 33},
          '{MD_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         33},
          '{MD_DIVU, 32'd5,          32'd7,         32'h0,         33}};
    for (int i = 0; i < 10; i++) begin
      runOp(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("[TB] FAIL div%0d result: got %h want %h", i, res, v[i].exp); end
      checks++; if (z !== (v[i].exp == 32'h0)) begin errors++; $display("[TB] FAIL div%0d zero: got %b want %b", i, z, (v[i].exp == 32'h0)); end
      checks++; if (lat != v[i].lat) begin errors++; $display("[TB] FAIL div%0d latency: got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_special();
    vec_t v[5];
    logic [31:0] res; logic z; int lat;
    v = '{'{MD_DIV,  32'd7,         32'h0,         32'hFFFF_FFFF, 1},
          '{MD_REMU, 32'd7,         32'h0,         32'd7,         1},
          '{MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
          '{MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1},
          '{MD_REM,  32'h0,         32'h0,         32'h0,         1}};
    for (int i = 0; i < 5; i++) begin
      runOp(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("[TB] FAIL spc%0d result: got %h want %h", i, res, v[i].exp); end
      checks++; if (z !== (v[i].exp == 32'h0)) begin errors++; $display("[TB] FAIL spc%0d zero: got %b want %b", i, z, (v[i].exp == 32'h0)); end
      checks++; if (lat != v[i].lat) begin errors++; $display("[TB] FAIL spc%0d latency: got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    reqValid = 1'b1; mdOp = MD_MUL; srcA = 32'd6; srcB = 32'd7;
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 33) begin errors++; $display("[TB] FAIL bp latency: got %0d want 33", lat); end
    // Hold the response while a competing request is presented.
    reqValid = 1'b1; mdOp = MD_DIVU; srcA = 32'd1; srcB = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (result !== 32'd42) begin errors++; $display("[TB] FAIL bp hold%0d result: got %h want %h", i, result, 32'd42); end
      checks++; if (respValid !== 1'b1) begin errors++; $display("[TB] FAIL bp hold%0d respValid: got %b want 1", i, respValid); end
      checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL bp hold%0d reqReady: got %b want 0", i, reqReady); end
    end
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    checks++; if (respValid !== 1'b0) begin errors++; $display("[TB] FAIL bp release respValid: got %b want 0", respValid); end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL bp release reqReady: got %b want 1", reqReady); end
    reqValid = 1'b0;
    @(posedge clk); #1;
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL bp idle reqReady: got %b want 1", reqReady); end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] res; logic z; int lat; bit sawResp;
    reqValid = 1'b1; mdOp = MD_MUL; srcA = 32'h0001_2345; srcB = 32'h0000_0777;
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (respValid !== 1'b0) begin errors++; $display("[TB] FAIL abort respValid: got %b want 0", respValid); end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("[TB] FAIL abort reqReady: got %b want 1", reqReady); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL abort result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL abort zero: got %b want 1", zero); end
    sawResp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (respValid) sawResp = 1'b1;
    end
    checks++; if (sawResp !== 1'b0) begin errors++; $display("[TB] FAIL abort stray response: got %b want 0", sawResp); end
    runOp(MD_MUL, 32'd3, 32'd4, res, z, lat);
    checks++; if (res !== 32'd12) begin errors++; $display("[TB] FAIL post-abort result: got %h want %h", res, 32'd12); end
    checks++; if (lat != 33) begin errors++; $display("[TB] FAIL post-abort latency: got %0d want 33", lat); end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_special();
    test_backpressure();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
